// File: rtl/rd53_mon_scan_ctrl_if.sv
// Bus bundle between the monitoring scan sequencer and its surroundings
// (control, ADC handshake, result stream and result-bank read port).
interface rd53_mon_scan_ctrl_if #(
    parameter int unsigned N_CH     = 40,
    parameter int unsigned ADC_W    = 12,
    parameter int unsigned SETTLE_W = 8,
    parameter int unsigned CH_W     = $clog2(N_CH)
);
    logic                scan_start;
    logic                scan_stop;
    logic                scan_cont;
    logic [N_CH-1:0]     ch_mask;
    logic [SETTLE_W-1:0] settle_cyc;
    logic [N_CH-1:0]     mon_vin_sel;
    logic                adc_soc;
    logic                adc_eoc_b;
    logic [ADC_W-1:0]    adc_out;
    logic                res_valid;
    logic [CH_W-1:0]     res_ch;
    logic [ADC_W-1:0]    res_data;
    logic [CH_W-1:0]     rd_addr;
    logic [ADC_W-1:0]    rd_data;
    logic                busy;
    logic                scan_done;
    logic                timeout_err;

    modport master (
        output scan_start, scan_stop, scan_cont, ch_mask, settle_cyc,
        output adc_eoc_b, adc_out, rd_addr,
        input  mon_vin_sel, adc_soc, res_valid, res_ch, res_data,
        input  rd_data, busy, scan_done, timeout_err
    );

    modport slave (
        input  scan_start, scan_stop, scan_cont, ch_mask, settle_cyc,
        input  adc_eoc_b, adc_out, rd_addr,
        output mon_vin_sel, adc_soc, res_valid, res_ch, res_data,
        output rd_data, busy, scan_done, timeout_err
    );
endinterface

// File: rtl/rd53_mon_scan_ctrl.sv
// Autonomous monitoring scan sequencer: walks a masked set of MUX channels,
// settles, averages 2**AVG_LOG2 ADC conversions per channel and stores/streams results.
module rd53_mon_scan_ctrl #(
    parameter int unsigned N_CH     = 40,
    parameter int unsigned ADC_W    = 12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned SETTLE_W = 8,
    parameter int unsigned TO_CYC   = 255,
    parameter int unsigned CH_W     = $clog2(N_CH)
) (
    input logic                 clk40,
    input logic                 rst,
    rd53_mon_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_CH + 1);
    localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
    localparam int unsigned SMP_W = AVG_LOG2 + 1;
    localparam int unsigned N_AVG = 1 << AVG_LOG2;
    localparam int unsigned TO_W  = $clog2(TO_CYC + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEEK   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SOC    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;

    logic [2:0]          state, state_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [CH_W-1:0]     cur_ch, ch_d;
    logic [SETTLE_W-1:0] settle_cnt, settle_d;
    logic [TO_W-1:0]     to_cnt, to_d;
    logic [SMP_W-1:0]    smp_cnt, smp_d;
    logic [ACC_W-1:0]    acc, acc_d;
    logic                to_flag, to_flag_d;
    logic                eoc_b_q;

    logic [N_CH-1:0]     sel_q, sel_d;
    logic                soc_q, soc_d;
    logic                valid_q, valid_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [ADC_W-1:0]    res_data_q, res_data_d;
    logic                busy_q;
    logic                done_q, done_d;
    logic                terr_q, terr_d;

    logic [ADC_W-1:0]    bank [N_CH];

    logic [N_CH-1:0]     cand_c;
    logic                found_c;
    logic [CH_W-1:0]     found_ch_c;
    logic                eoc_fall_c;
    logic [ADC_W-1:0]    result_c;
    logic                wr_en_c;

    // Lowest enabled channel at or above the current index
    always_comb begin
        cand_c     = mask_q & ~((N_CH'(1) << idx) - N_CH'(1));
        found_c    = 1'b0;
        found_ch_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (cand_c[i] && !found_c) begin
                found_c    = 1'b1;
                found_ch_c = CH_W'(i);
            end
        end
    end

    // Only a fresh high-to-low transition counts; a lingering low level does not
    assign eoc_fall_c = !bus.adc_eoc_b && eoc_b_q;
    assign result_c   = to_flag ? '1 : ADC_W'(acc >> AVG_LOG2);

    always_comb begin
        state_d    = state;
        mask_d     = mask_q;
        idx_d      = idx;
        ch_d       = cur_ch;
        settle_d   = settle_cnt;
        to_d       = to_cnt;
        smp_d      = smp_cnt;
        acc_d      = acc;
        to_flag_d  = to_flag;
        sel_d      = sel_q;
        soc_d      = 1'b0;
        valid_d    = 1'b0;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
        done_d     = 1'b0;
        terr_d     = 1'b0;
        wr_en_c    = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.scan_start && !bus.scan_stop) begin
                    state_d = S_SEEK;
                    mask_d  = bus.ch_mask;
                    idx_d   = '0;
                end
            end
            S_SEEK: begin
                if (found_c) begin
                    ch_d     = found_ch_c;
                    sel_d    = N_CH'(1) << found_ch_c;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end else begin
                    done_d = 1'b1;
                    if (bus.scan_cont) begin
                        mask_d = bus.ch_mask;
                        idx_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        sel_d   = '0;
                    end
                end
            end
            S_SETTLE: begin
                if ((SETTLE_W+1)'(settle_cnt) + (SETTLE_W+1)'(1) >= (SETTLE_W+1)'(bus.settle_cyc)) begin
                    state_d = S_SOC;
                    soc_d   = 1'b1;
                end else begin
                    settle_d = settle_cnt + SETTLE_W'(1);
                end
            end
            S_SOC: begin
                to_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eoc_fall_c) begin
                    acc_d = acc + ACC_W'(bus.adc_out);
                    if (smp_cnt == SMP_W'(N_AVG - 1)) begin
                        state_d = S_STORE;
                    end else begin
                        smp_d   = smp_cnt + SMP_W'(1);
                        state_d = S_SOC;
                        soc_d   = 1'b1;
                    end
                end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                    terr_d    = 1'b1;
                    to_flag_d = 1'b1;
                    state_d   = S_STORE;
                end else begin
                    to_d = to_cnt + TO_W'(1);
                end
            end
            S_STORE: begin
                wr_en_c    = 1'b1;
                valid_d    = 1'b1;
                res_ch_d   = cur_ch;
                res_data_d = result_c;
                acc_d      = '0;
                smp_d      = '0;
                to_flag_d  = 1'b0;
                idx_d      = IDX_W'(cur_ch) + IDX_W'(1);
                state_d    = S_SEEK;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a same-cycle bank write
        if (bus.scan_stop && state != S_IDLE) begin
            state_d    = S_IDLE;
            sel_d      = '0;
            soc_d      = 1'b0;
            valid_d    = 1'b0;
            done_d     = 1'b0;
            terr_d     = 1'b0;
            wr_en_c    = 1'b0;
            acc_d      = '0;
            smp_d      = '0;
            to_flag_d  = 1'b0;
            res_ch_d   = res_ch_q;
            res_data_d = res_data_q;
        end
    end

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mask_q     <= '0;
            idx        <= '0;
            cur_ch     <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            smp_cnt    <= '0;
            acc        <= '0;
            to_flag    <= 1'b0;
            eoc_b_q    <= 1'b0;
            sel_q      <= '0;
            soc_q      <= 1'b0;
            valid_q    <= 1'b0;
            res_ch_q   <= '0;
            res_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            for (int i = 0; i < int'(N_CH); i++) bank[i] <= '0;
        end else begin
            state      <= state_d;
            mask_q     <= mask_d;
            idx        <= idx_d;
            cur_ch     <= ch_d;
            settle_cnt <= settle_d;
            to_cnt     <= to_d;
            smp_cnt    <= smp_d;
            acc        <= acc_d;
            to_flag    <= to_flag_d;
            eoc_b_q    <= bus.adc_eoc_b;
            sel_q      <= sel_d;
            soc_q      <= soc_d;
            valid_q    <= valid_d;
            res_ch_q   <= res_ch_d;
            res_data_q <= res_data_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            terr_q     <= terr_d;
            if (wr_en_c) bank[cur_ch] <= result_c;
        end
    end

    always_comb begin
        if ({1'b0, bus.rd_addr} < (CH_W+1)'(N_CH)) bus.rd_data = bank[bus.rd_addr];
        else                                       bus.rd_data = '0;
    end

    assign bus.mon_vin_sel = sel_q;
    assign bus.adc_soc     = soc_q;
    assign bus.res_valid   = valid_q;
    assign bus.res_ch      = res_ch_q;
    assign bus.res_data    = res_data_q;
    assign bus.busy        = busy_q;
    assign bus.scan_done   = done_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_rd53_mon_scan_ctrl.sv
// Directed bench for rd53_mon_scan_ctrl with a behavioural ADC that answers
// each SOC with a single falling EOC edge two cycles later.
module tb_rd53_mon_scan_ctrl;
    localparam int unsigned N_CH     = 40;
    localparam int unsigned ADC_W    = 12;
    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned CH_W     = 6;

    logic clk;
    logic rst;

    rd53_mon_scan_ctrl_if #(.N_CH(N_CH), .ADC_W(ADC_W), .SETTLE_W(SETTLE_W), .CH_W(CH_W)) bus ();

    rd53_mon_scan_ctrl #(
        .N_CH(N_CH), .ADC_W(ADC_W), .AVG_LOG2(2), .SETTLE_W(SETTLE_W), .TO_CYC(255), .CH_W(CH_W)
    ) dut (
        .clk40(clk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ADC model: ch0 yields 100,101,...; ch39 yields 2000; ch5 never answers; others 4095
    int k0 = 0;
    always @(negedge clk) begin
        if (bus.adc_soc && !bus.mon_vin_sel[5]) begin
            repeat (2) @(negedge clk);
            if (bus.mon_vin_sel[0]) begin
                bus.adc_out = ADC_W'(100 + k0);
                k0++;
            end else if (bus.mon_vin_sel[39]) begin
                bus.adc_out = ADC_W'(2000);
            end else begin
                bus.adc_out = ADC_W'(4095);
            end
            bus.adc_eoc_b = 1'b0;
            @(posedge clk);
            #1 bus.adc_eoc_b = 1'b1;
        end
    end

    // Event counters and result log
    int soc_cnt = 0, val_cnt = 0, done_cnt = 0, terr_cnt = 0;
    logic [CH_W-1:0]  log_ch   [64];
    logic [ADC_W-1:0] log_data [64];
    always @(negedge clk) begin
        if (bus.adc_soc)     soc_cnt++;
        if (bus.scan_done)   done_cnt++;
        if (bus.timeout_err) terr_cnt++;
        if (bus.res_valid) begin
            if (val_cnt < 64) begin
                log_ch[val_cnt]   = bus.res_ch;
                log_data[val_cnt] = bus.res_data;
            end
            val_cnt++;
        end
    end

    int s_soc, s_val, s_done, s_terr;
    task automatic snap();
        s_soc  = soc_cnt;
        s_val  = val_cnt;
        s_done = done_cnt;
        s_terr = terr_cnt;
    endtask

    task automatic start_scan(input logic [N_CH-1:0] mask, input int settle, input logic cont);
        @(negedge clk);
        bus.ch_mask    = mask;
        bus.settle_cyc = SETTLE_W'(settle);
        bus.scan_cont  = cont;
        bus.scan_start = 1'b1;
        @(negedge clk);
        bus.scan_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic read_bank(input int a, output logic [ADC_W-1:0] d);
        bus.rd_addr = CH_W'(a);
        #1 d = bus.rd_data;
    endtask

    initial begin
        int n, nv, nidle;
        logic [ADC_W-1:0] d;

        bus.scan_start = 1'b0;
        bus.scan_stop  = 1'b0;
        bus.scan_cont  = 1'b0;
        bus.ch_mask    = '0;
        bus.settle_cyc = '0;
        bus.adc_eoc_b  = 1'b1;
        bus.adc_out    = '0;
        bus.rd_addr    = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sel", bus.mon_vin_sel, 0);
        chk("rst_soc", bus.adc_soc, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_done", bus.scan_done, 0);
        chk("rst_res_data", bus.res_data, 0);
        read_bank(0, d);
        chk("rst_bank0", d, 0);
        rst = 1'b0;
        @(negedge clk);

        // Two-channel scan with averaging and settle timing
        k0 = 0;
        snap();
        start_scan(40'h5, 3, 1'b0);
        n = 0;
        while (bus.mon_vin_sel == '0 && n < 50) begin @(negedge clk); n++; end
        chk("t1_sel_onehot", bus.mon_vin_sel, 40'h1);
        chk("t1_no_soc_before_sel", soc_cnt - s_soc, 0);
        n = 0;
        while (!bus.adc_soc && n < 50) begin n++; @(negedge clk); end
        chk("t1_settle_cycles", n, 3);
        wait_idle(2000);
        chk("t1_busy_end", bus.busy, 0);
        chk("t1_valid_cnt", val_cnt - s_val, 2);
        chk("t1_res0_ch", log_ch[s_val], 0);
        chk("t1_res0_data", log_data[s_val], 101);
        chk("t1_res1_ch", log_ch[s_val+1], 2);
        chk("t1_res1_data", log_data[s_val+1], 4095);
        read_bank(0, d);
        chk("t1_bank0", d, 101);
        read_bank(2, d);
        chk("t1_bank2", d, 4095);
        chk("t1_soc_cnt", soc_cnt - s_soc, 8);
        chk("t1_done_cnt", done_cnt - s_done, 1);

        // Empty mask: done two cycles after start, no conversions
        snap();
        start_scan('0, 3, 1'b0);
        chk("t2_done_n1", bus.scan_done, 0);
        @(negedge clk);
        chk("t2_done_n2", bus.scan_done, 1);
        chk("t2_busy_n2", bus.busy, 0);
        @(negedge clk);
        chk("t2_done_n3", bus.scan_done, 0);
        chk("t2_soc_cnt", soc_cnt - s_soc, 0);
        chk("t2_valid_cnt", val_cnt - s_val, 0);

        // Start and stop together while idle
        bus.ch_mask    = 40'h5;
        bus.scan_start = 1'b1;
        bus.scan_stop  = 1'b1;
        @(negedge clk);
        bus.scan_start = 1'b0;
        bus.scan_stop  = 1'b0;
        chk("t2b_busy", bus.busy, 0);
        @(negedge clk);
        chk("t2b_busy2", bus.busy, 0);

        // EOC timeout on a mute channel
        snap();
        start_scan(40'h20, 2, 1'b0);
        n = 0;
        while (!bus.adc_soc && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        n = 0;
        while (!bus.timeout_err && n < 400) begin n++; @(negedge clk); end
        chk("t3_timeout_cycles", n, 255);
        wait_idle(100);
        chk("t3_busy_end", bus.busy, 0);
        read_bank(5, d);
        chk("t3_bank5", d, 12'hFFF);
        chk("t3_res_ch", log_ch[s_val], 5);
        chk("t3_res_data", log_data[s_val], 4095);
        chk("t3_terr_cnt", terr_cnt - s_terr, 1);
        chk("t3_done_cnt", done_cnt - s_done, 1);
        chk("t3_soc_cnt", soc_cnt - s_soc, 1);

        // Continuous mode on the top channel
        snap();
        start_scan(N_CH'(1) << 39, 1, 1'b1);
        nv = 0;
        nidle = 0;
        n = 0;
        while (nv < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!bus.busy) nidle++;
            if (bus.res_valid) nv++;
        end
        bus.scan_cont = 1'b0;
        chk("t4_results", nv, 3);
        chk("t4_idle_cycles", nidle, 0);
        wait_idle(300);
        chk("t4_busy_end", bus.busy, 0);
        for (int k = 0; k < 3; k++) begin
            chk("t4_res_ch", log_ch[s_val+k], 39);
            chk("t4_res_data", log_data[s_val+k], 2000);
        end
        chk("t4_valid_cnt", val_cnt - s_val, 3);
        chk("t4_done_cnt", done_cnt - s_done, 3);

        // Abort during the second channel's conversion wait
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        k0 = 0;
        snap();
        start_scan(40'h5, 3, 1'b0);
        n = 0;
        while (!(bus.adc_soc && bus.mon_vin_sel[2]) && n < 500) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.scan_stop = 1'b1;
        @(negedge clk);
        bus.scan_stop = 1'b0;
        chk("t5_busy", bus.busy, 0);
        chk("t5_sel", bus.mon_vin_sel, 0);
        chk("t5_soc", bus.adc_soc, 0);
        repeat (20) @(negedge clk);
        chk("t5_soc_cnt", soc_cnt - s_soc, 5);
        chk("t5_valid_cnt", val_cnt - s_val, 1);
        chk("t5_done_cnt", done_cnt - s_done, 0);
        chk("t5_res_data_hold", bus.res_data, 101);
        read_bank(0, d);
        chk("t5_bank0", d, 101);
        read_bank(2, d);
        chk("t5_bank2", d, 0);

        // Asynchronous reset in the middle of settling
        start_scan(40'h5, 10, 1'b0);
        n = 0;
        while (bus.mon_vin_sel == '0 && n < 50) begin @(negedge clk); n++; end
        chk("t6_sel_before", bus.mon_vin_sel, 40'h1);
        #2 rst = 1'b1;
        #1;
        chk("t6_sel", bus.mon_vin_sel, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_soc", bus.adc_soc, 0);
        chk("t6_valid", bus.res_valid, 0);
        chk("t6_res_data", bus.res_data, 0);
        chk("t6_res_ch", bus.res_ch, 0);
        for (int a = 0; a < int'(N_CH); a++) begin
            read_bank(a, d);
            chk("t6_bank", d, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rd53_mon_scan_ctrl.md
Name: rd53_mon_scan_ctrl

Overview:
- Parametrised autonomous scan sequencer for the monitoring block.
- Walks a masked set of analog-MUX channels and drives the one-hot MUX select.
- Per channel: waits a programmable settling time, then issues N ADC conversions and averages them.
- Writes each averaged result to a readable result bank and streams it out. Supports single-shot and continuous scan.

Parameters:
- N_CH, 40: number of MUX inputs; channel 0 is the bandgap.
- ADC_W, 12: ADC output width.
- AVG_LOG2, 2: log2 of the samples averaged per channel (0 = no averaging).
- SETTLE_W, 8: width of the settle-count input.
- TO_CYC, 255: EOC timeout in cycles.
- CH_W, $clog2(N_CH): channel index width.

Ports:
- CLK40  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- SCAN_START  in  1  start request, level-sampled in IDLE.
- SCAN_STOP  in  1  abort, sampled every cycle.
- SCAN_CONT  in  1  continuous mode: restart after the last channel.
- CH_MASK  in  N_CH  channel enable mask.
- SETTLE_CYC  in  SETTLE_W  settle cycles after each select change.
- MON_VIN_SEL  out  N_CH  one-hot MUX select; all-zero means disconnected.
- ADC_SOC  out  1  start-of-conversion pulse.
- ADC_EOC_B  in  1  active-low end of conversion.
- ADC_OUT  in  ADC_W  conversion result, valid when ADC_EOC_B is low.
- RES_VALID  out  1  one-cycle result strobe.
- RES_CH  out  CH_W  channel of the current result.
- RES_DATA  out  ADC_W  averaged result.
- RD_ADDR  in  CH_W  result-bank read address.
- RD_DATA  out  ADC_W  bank[RD_ADDR], combinational read.
- BUSY  out  1  high in any state other than IDLE.
- SCAN_DONE  out  1  one-cycle end-of-pass pulse.
- TIMEOUT_ERR  out  1  one-cycle pulse on EOC timeout.

Behaviour:
- Reset: all outputs 0; bank cleared to 0; FSM enters IDLE; index 0.
- States: IDLE, SEEK, SETTLE, SOC, WAIT_EOC, STORE.
- IDLE -> SEEK: on SCAN_START=1. CH_MASK is latched on this edge into mask_q. SCAN_START while BUSY is ignored.
- SEEK (1 cycle): a priority search from the current index upward picks the lowest enabled channel ≥ index.
  - Channel found: MON_VIN_SEL = one-hot(channel), registered, updated on the SEEK->SETTLE edge; go to SETTLE.
  - No channel found: SCAN_DONE pulses.
    - SCAN_CONT=1: re-latch CH_MASK, set index to 0, stay in SEEK.
    - Otherwise: go to IDLE; MON_VIN_SEL returns to 0.
  - Empty mask: SCAN_DONE 2 cycles after start; no SOC is issued. In continuous mode SCAN_DONE pulses every cycle.
- SETTLE: count SETTLE_CYC cycles, then go to SOC. SETTLE_CYC=0 passes through SETTLE in a single cycle.
- SOC: ADC_SOC=1 for exactly 1 cycle; the timeout counter is cleared.
- WAIT_EOC:
  - Completion event = falling edge of ADC_EOC_B (current 0, previous registered 1). A stale low level is not accepted.
  - On the event, acc += ADC_OUT. acc is ADC_W+AVG_LOG2 bits wide and cannot overflow.
  - Samples remaining: go to SOC with no re-settle. Otherwise go to STORE.
  - Timeout: counter reaches TO_CYC with no event. TIMEOUT_ERR pulses; the channel result is forced to all-ones; remaining samples are skipped; go to STORE.
- STORE (1 cycle):
  - result = acc >> AVG_LOG2 (truncating), or all-ones after a timeout.
  - bank[ch] <= result; RES_VALID=1, RES_CH=ch, RES_DATA=result.
  - Clear acc; index = ch+1; go to SEEK.
  - Wrap: ch = N_CH-1 -> index N_CH, so the next SEEK sees end of pass.
- RES_CH and RES_DATA hold their values between strobes.
- RD_DATA reflects a bank write from the cycle after STORE.
- SCAN_STOP=1 in any non-IDLE state:
  - Go to IDLE next cycle; MON_VIN_SEL=0; ADC_SOC=0; acc cleared.
  - No RES_VALID and no SCAN_DONE; the bank keeps prior values.
  - SCAN_STOP takes priority over a same-cycle STORE; that write is dropped.
- SCAN_STOP and SCAN_START in the same cycle while IDLE: remain IDLE.
- Mid-operation CH_MASK changes have no effect until the next latch.
- Asserting RST mid-scan: immediate return to reset state; no partial writes.

Test Plan:
- Mask=0x0000000005, SETTLE=3, AVG_LOG2=2; ADC model returns 100,101,102,103 on ch0 and 4095×4 on ch2. Required: RES_DATA=101 ch0, then 4095 ch2; bank[0]=101, bank[2]=4095; exactly 8 SOC pulses; SCAN_DONE once; BUSY low afterwards.
- Same run, checking timing: MON_VIN_SEL goes one-hot before the first SOC; the first SOC occurs 3 settle cycles after the select change.
- Mask=0, SCAN_START -> SCAN_DONE 2 cycles later, no ADC_SOC, no RES_VALID.
- ADC model never asserts EOC on ch5 (mask bit5 only) -> TIMEOUT_ERR after 255 cycles; bank[5]=0xFFF; SCAN_DONE follows.
- SCAN_CONT=1, mask=ch39 only -> repeated RES_VALID with RES_CH=39; each SCAN_DONE precedes a re-scan with no IDLE in between. Drop SCAN_CONT -> returns to IDLE after the current pass.
- SCAN_STOP during WAIT_EOC of the second channel -> IDLE next cycle, MON_VIN_SEL=0, no further SOC; bank keeps only the first channel.
- Async RST mid-SETTLE -> all outputs 0 immediately; bank reads 0 at every address.
